// File: rtl/divider_arb_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
package divider_arb_pkg;

    localparam int REQ_CNT         = 2;
    localparam int ID_W            = $clog2(REQ_CNT);
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_FRAC_W      = 8;
    localparam int DEF_DIV_LATENCY = 20;

    // Travels alongside an operation through the divider so its quotient can be
    // routed back to the owner.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dbz;
    } tag_t;

endpackage

// File: rtl/divider_tag_pipe.sv
// Fixed-depth shift register of operation tags; a synchronous clear drops all
// in-flight tags so their quotients are never reported.
module divider_tag_pipe
    import divider_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DIV_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    // Shift one position per cycle; clear has priority over a new push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one external fixed-latency divider between the
// Cr and Cb mean-chroma paths, with zero-divisor trapping and tagged routing
// of quotients back to their owners.
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req0_valid,
    output logic                               req0_ready,
    input  logic [DATA_W-1:0]                  req0_dividend,
    input  logic [DATA_W-1:0]                  req0_divisor,
    input  logic                               req1_valid,
    output logic                               req1_ready,
    input  logic [DATA_W-1:0]                  req1_dividend,
    input  logic [DATA_W-1:0]                  req1_divisor,
    input  logic                               div_rfd,
    output logic                               div_nd,
    output logic [DATA_W-1:0]                  div_dividend,
    output logic [DATA_W-1:0]                  div_divisor,
    input  logic [DATA_W-1:0]                  div_quotient,
    input  logic [FRAC_W-1:0]                  div_fractional,
    output logic                               res0_valid,
    output logic [DATA_W+FRAC_W-1:0]           res0_data,
    output logic                               res0_dbz,
    output logic                               res1_valid,
    output logic [DATA_W+FRAC_W-1:0]           res1_data,
    output logic                               res1_dbz,
    output logic [$clog2(DIV_LATENCY+1)-1:0]   inflight
);

    localparam int CNT_W = $clog2(DIV_LATENCY+1);
    localparam int RES_W = DATA_W + FRAC_W;

    logic              gnt0;
    logic              gnt1;
    logic              issue;
    logic              rr_q;
    logic              rr_d;
    logic [DATA_W-1:0] sel_dividend;
    logic [DATA_W-1:0] sel_divisor;
    logic              sel_zero;

    logic              nd_q;
    logic [DATA_W-1:0] dividend_q;
    logic [DATA_W-1:0] divisor_q;
    logic [ID_W-1:0]   id_q;
    logic              dbz_q;

    tag_t              tag_in;
    tag_t              tag_out;

    logic [REQ_CNT-1:0] res_valid_q;
    logic [RES_W-1:0]   res_data_q [REQ_CNT];
    logic [REQ_CNT-1:0] res_dbz_q;

    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;

    // Grant: a lone requester always wins; when both are valid rr_q picks one.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && div_rfd) begin
            if (req0_valid && (!req1_valid || !rr_q)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
        issue        = gnt0 | gnt1;
        rr_d         = issue ? gnt0 : rr_q;
        sel_dividend = gnt1 ? req1_dividend : req0_dividend;
        sel_divisor  = gnt1 ? req1_divisor  : req0_divisor;
        sel_zero     = (sel_divisor == '0);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Issue register; a zero divisor is replaced by the harmless 0/1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= 1'b0;
            nd_q       <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            id_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            rr_q <= rr_d;
            nd_q <= issue;
            if (issue) begin
                dividend_q <= sel_zero ? '0 : sel_dividend;
                divisor_q  <= sel_zero ? DATA_W'(1) : sel_divisor;
                id_q       <= ID_W'(gnt1);
                dbz_q      <= sel_zero;
            end
        end
    end

    assign div_nd       = nd_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

    // Tag for the operation currently presented to the divider.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = nd_q;
        tag_in.id    = id_q;
        tag_in.dbz   = dbz_q;
    end

    divider_tag_pipe #(
        .DEPTH (DIV_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Route an emerging quotient to the port named by its tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= '0;
            res_dbz_q   <= '0;
            for (int p = 0; p < REQ_CNT; p++) begin
                res_data_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < REQ_CNT; p++) begin
                res_valid_q[p] <= tag_out.valid && (int'(tag_out.id) == p);
                if (tag_out.valid && (int'(tag_out.id) == p)) begin
                    res_data_q[p] <= tag_out.dbz ? '0 : {div_quotient, div_fractional};
                    res_dbz_q[p]  <= tag_out.dbz;
                end
            end
        end
    end

    assign res0_valid = res_valid_q[0];
    assign res1_valid = res_valid_q[1];
    assign res0_data  = res_data_q[0];
    assign res1_data  = res_data_q[1];
    assign res0_dbz   = res_dbz_q[0];
    assign res1_dbz   = res_dbz_q[1];

    // Occupancy: up on push into the divider, down when a tag emerges.
    always_comb begin
        inflight_d = inflight_q;
        if (nd_q && !tag_out.valid) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!nd_q && tag_out.valid) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with an emulated fixed-latency divider
// and a transaction-level reference model checked every cycle.
module tb_divider_arbiter;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int L  = 4;
    localparam int CW = $clog2(L+1);

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [DW-1:0]  req0_dividend, req0_divisor, req1_dividend, req1_divisor;
    logic           div_rfd;
    logic           div_nd;
    logic [DW-1:0]  div_dividend, div_divisor;
    logic [DW-1:0]  div_quotient;
    logic [FW-1:0]  div_fractional;
    logic           res0_valid, res1_valid;
    logic [DW+FW-1:0] res0_data, res1_data;
    logic           res0_dbz, res1_dbz;
    logic [CW-1:0]  inflight;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider_arbiter #(
        .DATA_W      (DW),
        .FRAC_W      (FW),
        .DIV_LATENCY (L)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_dividend  (req0_dividend),
        .req0_divisor   (req0_divisor),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_dividend  (req1_dividend),
        .req1_divisor   (req1_divisor),
        .div_rfd        (div_rfd),
        .div_nd         (div_nd),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_quotient   (div_quotient),
        .div_fractional (div_fractional),
        .res0_valid     (res0_valid),
        .res0_data      (res0_data),
        .res0_dbz       (res0_dbz),
        .res1_valid     (res1_valid),
        .res1_data      (res1_data),
        .res1_dbz       (res1_dbz),
        .inflight       (inflight)
    );

    // Ideal division: {integer quotient, 8-bit fraction of the remainder}.
    function automatic logic [DW+FW-1:0] ref_div(input logic [DW-1:0] dd, input logic [DW-1:0] dv);
        int qq, rm, ff;
        if (dv == '0) return '0;
        qq = int'(dd) / int'(dv);
        rm = int'(dd) % int'(dv);
        ff = (rm * 256) / int'(dv);
        return {qq[15:0], ff[7:0]};
    endfunction

    // External divider stand-in: result appears L cycles after the operands.
    logic [DW+FW-1:0] d_pipe [L];
    always @(posedge clk) begin
        d_pipe[0] <= ref_div(div_dividend, div_divisor);
        for (int i = 1; i < L; i++) d_pipe[i] <= d_pipe[i-1];
    end
    assign div_quotient   = d_pipe[L-1][DW+FW-1:FW];
    assign div_fractional = d_pipe[L-1][FW-1:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: list of accepted operations with their handshake cycle.
    typedef struct {
        int           t;
        bit           port;
        logic [DW-1:0] dd;
        logic [DW-1:0] dv;
    } op_t;

    op_t           ops[$];
    bit            m_rr   = 1'b0;
    bit            m_nd   = 1'b0;
    bit            m_dchk = 1'b1;
    logic [DW-1:0] m_dd   = '0;
    logic [DW-1:0] m_dv   = '0;

    always @(negedge clk) begin
        bit            e0, e1, ev0, ev1, eb0, eb1;
        logic [DW+FW-1:0] ed0, ed1;
        logic [DW-1:0] sdd, sdv;
        int            ef;
        if (cyc > 0) begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (!rst && div_rfd) begin
                if (req0_valid && req1_valid) begin
                    if (m_rr) e1 = 1'b1; else e0 = 1'b1;
                end else if (req0_valid) e0 = 1'b1;
                else if (req1_valid) e1 = 1'b1;
            end
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("div_nd", 32'(div_nd), 32'(m_nd));
            if (m_dchk) begin
                chk("div_dividend", 32'(div_dividend), 32'(m_dd));
                chk("div_divisor", 32'(div_divisor), 32'(m_dv));
            end
            ev0 = 0; ev1 = 0; eb0 = 0; eb1 = 0; ed0 = '0; ed1 = '0; ef = 0;
            foreach (ops[i]) begin
                if (ops[i].t + L + 2 == cyc) begin
                    if (ops[i].port) begin
                        ev1 = 1; eb1 = (ops[i].dv == '0); ed1 = ref_div(ops[i].dd, ops[i].dv);
                    end else begin
                        ev0 = 1; eb0 = (ops[i].dv == '0); ed0 = ref_div(ops[i].dd, ops[i].dv);
                    end
                end
                if (ops[i].t + 2 <= cyc && cyc <= ops[i].t + L + 1) ef++;
            end
            chk("res0_valid", 32'(res0_valid), 32'(ev0));
            chk("res1_valid", 32'(res1_valid), 32'(ev1));
            if (ev0) begin
                chk("res0_data", 32'(res0_data), 32'(ed0));
                chk("res0_dbz", 32'(res0_dbz), 32'(eb0));
            end
            if (ev1) begin
                chk("res1_data", 32'(res1_data), 32'(ed1));
                chk("res1_dbz", 32'(res1_dbz), 32'(eb1));
            end
            chk("inflight", 32'(inflight), 32'(ef));
            if (rst) begin
                m_rr = 0; m_nd = 0; m_dd = '0; m_dv = '0; m_dchk = 1;
                ops.delete();
            end else begin
                m_nd   = e0 | e1;
                m_dchk = e0 | e1;
                if (e0 | e1) begin
                    sdd = e1 ? req1_dividend : req0_dividend;
                    sdv = e1 ? req1_divisor  : req0_divisor;
                    ops.push_back('{cyc, e1, sdd, sdv});
                    m_dd = (sdv == '0) ? '0 : sdd;
                    m_dv = (sdv == '0) ? DW'(1) : sdv;
                    m_rr = e0;
                end
                while (ops.size() > 0 && ops[0].t + L + 2 <= cyc) void'(ops.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit r0;
        int imax;
        rst = 1'b1; div_rfd = 1'b1;
        req0_valid = 1'b1; req0_dividend = 16'd7; req0_divisor = 16'd7;
        req1_valid = 1'b0; req1_dividend = '0;    req1_divisor = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_nd", 32'(div_nd), 32'd0);
        chk("rst_dividend", 32'(div_dividend), 32'd0);
        chk("rst_divisor", 32'(div_divisor), 32'd0);
        chk("rst_res0_valid", 32'(res0_valid), 32'd0);
        chk("rst_res0_data", 32'(res0_data), 32'd0);
        chk("rst_res1_dbz", 32'(res1_dbz), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        tick();
        rst = 1'b0; req0_valid = 1'b0;
        repeat (2) tick();

        // Single request 100/4 on req0
        tick();
        req0_valid = 1'b1; req0_dividend = 16'd100; req0_divisor = 16'd4;
        @(negedge clk);
        chk("t1_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_nd", 32'(div_nd), 32'd1);
        chk("t1_dividend", 32'(div_dividend), 32'd100);
        chk("t1_divisor", 32'(div_divisor), 32'd4);
        repeat (5) @(negedge clk);
        chk("t1_res0_valid", 32'(res0_valid), 32'd1);
        chk("t1_res0_data", 32'(res0_data), 32'h001900);
        chk("t1_res1_valid", 32'(res1_valid), 32'd0);

        // Divide by zero on req1
        tick();
        req1_valid = 1'b1; req1_dividend = 16'd50; req1_divisor = 16'd0;
        @(negedge clk);
        chk("dbz_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("dbz_divisor", 32'(div_divisor), 32'd1);
        chk("dbz_dividend", 32'(div_dividend), 32'd0);
        repeat (5) @(negedge clk);
        chk("dbz_res1_valid", 32'(res1_valid), 32'd1);
        chk("dbz_res1_data", 32'(res1_data), 32'd0);
        chk("dbz_res1_dbz", 32'(res1_dbz), 32'd1);

        // Both requesters valid for 6 cycles: grants alternate from req0
        tick();
        req0_valid = 1'b1; req0_dividend = 16'd1000; req0_divisor = 16'd3;
        req1_valid = 1'b1; req1_dividend = 16'd999;  req1_divisor = 16'd7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r0 = req0_ready;
            chk("alt_grant0", 32'(r0), 32'((i % 2) == 0));
            tick();
            if (r0) req0_dividend = req0_dividend + 16'd17;
            else    req1_dividend = req1_dividend + 16'd29;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // div_rfd low for 3 cycles with req0 waiting
        repeat (L + 4) tick();
        div_rfd = 1'b0; req0_valid = 1'b1; req0_dividend = 16'd77; req0_divisor = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rfd_low_ready", 32'(req0_ready), 32'd0);
            chk("rfd_low_inflight", 32'(inflight), 32'd0);
            tick();
        end
        div_rfd = 1'b1;
        @(negedge clk);
        chk("rfd_back_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;

        // Reset with 3 operations inside the divider
        repeat (L + 4) tick();
        req0_valid = 1'b1; req0_dividend = 16'd200; req0_divisor = 16'd9;
        tick(); req0_dividend = 16'd201;
        tick(); req0_dividend = 16'd202;
        tick(); req0_valid = 1'b0;
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_inflight3", 32'(inflight), 32'd3);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_inflight0", 32'(inflight), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_no_res0", 32'(res0_valid), 32'd0);
        end
        tick();
        req1_valid = 1'b1; req1_dividend = 16'd300; req1_divisor = 16'd12;
        @(negedge clk);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("post_rst_res1_valid", 32'(res1_valid), 32'd1);
        chk("post_rst_res1_data", 32'(res1_data), 32'h001900);

        // Back-to-back issue for L+5 cycles
        repeat (L + 4) tick();
        imax = 0;
        req0_valid = 1'b1;
        for (int i = 0; i < L + 5; i++) begin
            req0_dividend = 16'(1000 + i * 13);
            req0_divisor  = 16'(i + 1);
            @(negedge clk);
            if (int'(inflight) > imax) imax = int'(inflight);
            tick();
        end
        req0_valid = 1'b0;
        for (int i = 0; i < L + 4; i++) begin
            @(negedge clk);
            if (int'(inflight) > imax) imax = int'(inflight);
            tick();
        end
        chk("b2b_inflight_max", 32'(imax), 32'(L));
        chk("b2b_drained", 32'(inflight), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
